// File: rtl/mem_bus_arbiter.sv
// MEM-stage bus arbiter: shares the slave bus between the CPU pipeline and a DMA master,
// decodes slave selects, and bounds both DMA bursts and CPU monopoly.
module mem_bus_arbiter #(
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        sysclk,
  input  logic        Reset_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_rd,
  input  logic        dma_wr,
  input  logic        dma_last,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        sel_mem,
  output logic        sel_per,
  output logic        sel_uart,
  input  logic [31:0] bus_rdata
);

  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int SCW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [BCW-1:0] BEAT_MAX   = BCW'(MAX_BURST - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT - 1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           dma_gnt_q, dma_gnt_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic           cool_q, cool_d;

  logic cpu_active;
  logic own_dma;
  logic beat;
  logic grant_dma;
  logic release_dma;

  assign cpu_active = cpu_rd | cpu_wr;
  assign own_dma    = (state_q == OWN_DMA);
  assign beat       = dma_gnt_q & (dma_rd | dma_wr);

  // The CPU keeps the bus while it is busy, unless the DMA has waited long enough.
  assign grant_dma   = dma_req & ~cool_q & (~cpu_active | (starve_cnt_q == STARVE_MAX));
  assign release_dma = ~dma_req | (beat & (dma_last | (beat_cnt_q == BEAT_MAX)));

  always_comb begin
    state_d      = state_q;
    dma_gnt_d    = dma_gnt_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cool_d       = 1'b0;
    case (state_q)
      OWN_CPU: begin
        beat_cnt_d = '0;
        if (grant_dma) begin
          state_d      = OWN_DMA;
          dma_gnt_d    = 1'b1;
          starve_cnt_d = '0;
        end else if (!dma_req) begin
          starve_cnt_d = '0;
        end else if (cpu_active && (starve_cnt_q != STARVE_MAX)) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      OWN_DMA: begin
        starve_cnt_d = '0;
        if (release_dma) begin
          state_d    = OWN_CPU;
          dma_gnt_d  = 1'b0;
          beat_cnt_d = '0;
          cool_d     = 1'b1;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = OWN_CPU;
        dma_gnt_d = 1'b0;
      end
    endcase
  end

  // Reset abandons any burst in progress and hands the bus straight back to the CPU.
  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= OWN_CPU;
      dma_gnt_q    <= 1'b0;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      cool_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dma_gnt_q    <= dma_gnt_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cool_q       <= cool_d;
    end
  end

  assign dma_gnt   = dma_gnt_q;
  assign cpu_stall = cpu_active & own_dma;

  always_comb begin
    if (own_dma) begin
      bus_rd    = dma_rd;
      bus_wr    = dma_wr;
      bus_addr  = dma_addr;
      bus_wdata = dma_wdata;
      cpu_rdata = '0;
      dma_rdata = bus_rdata;
    end else begin
      bus_rd    = cpu_rd;
      bus_wr    = cpu_wr;
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
      cpu_rdata = bus_rdata;
      dma_rdata = '0;
    end
  end

  // Peripheral and UART share the 0x4xxxxxxx window, split on the low address byte.
  assign sel_mem  = (bus_addr[31:30] == 2'b00);
  assign sel_per  = (bus_addr[31:28] == 4'h4) && (bus_addr[7:0] < 8'h18);
  assign sel_uart = (bus_addr[31:28] == 4'h4) && (bus_addr[7:0] >= 8'h18) && (bus_addr[7:0] < 8'h20);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a zero-latency slave model on the shared bus.
module tb_mem_bus_arbiter;

  logic        sysclk = 1'b0;
  logic        Reset_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_rd, dma_wr, dma_last;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        sel_mem, sel_per, sel_uart;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.MAX_BURST(4), .STARVE_LIMIT(8)) dut (
    .sysclk(sysclk), .Reset_n(Reset_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_last(dma_last),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .sel_mem(sel_mem), .sel_per(sel_per), .sel_uart(sel_uart), .bus_rdata(bus_rdata)
  );

  always #5 sysclk = ~sysclk;

  // Slaves: each returns its address XOR a slave-specific tag, 0 when not selected.
  always_comb begin
    bus_rdata = '0;
    if (bus_rd) begin
      if (sel_mem)  bus_rdata = bus_rdata | (bus_addr ^ 32'h5A5A_0000);
      if (sel_per)  bus_rdata = bus_rdata | (bus_addr ^ 32'h0000_C300);
      if (sel_uart) bus_rdata = bus_rdata | (bus_addr ^ 32'h00FF_0000);
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  localparam logic [31:0] DEC_ADDR [6] = '{32'h0000_0FFC, 32'h4000_0014, 32'h4000_0018,
                                           32'h4000_001C, 32'h4000_0020, 32'h8000_0000};
  localparam logic [2:0]  DEC_SEL  [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000};
  localparam logic [31:0] DEC_DATA [6] = '{32'h5A5A_0FFC, 32'h4000_C314, 32'h40FF_0018,
                                           32'h40FF_001C, 32'h0000_0000, 32'h0000_0000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_gnt;
    int beat_no;
    int store_seen;

    Reset_n = 1'b0;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_rd = 0; dma_wr = 0; dma_last = 0; dma_addr = '0; dma_wdata = '0;

    // Reset state, CPU still reaches the bus while in reset
    #2;
    chk_eq("rst_gnt", 32'(dma_gnt), 32'd0);
    chk_eq("rst_stall", 32'(cpu_stall), 32'd0);
    chk_eq("rst_bus_rd", 32'(bus_rd), 32'd0);
    chk_eq("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk_eq("rst_dma_rdata", dma_rdata, 32'd0);
    cpu_rd = 1; cpu_addr = 32'h0000_0010;
    #1;
    chk_eq("rst_cpu_bus_rd", 32'(bus_rd), 32'd1);
    chk_eq("rst_cpu_rdata", cpu_rdata, 32'h5A5A_0010);
    cpu_rd = 0;
    @(negedge sysclk);
    Reset_n = 1'b1;
    next_cycle();

    // Idle CPU, three DMA writes ending on dma_last
    dma_req = 1; dma_wr = 1; dma_addr = 32'h100; dma_wdata = 32'h11;
    #2;
    chk_eq("t1_req_gnt", 32'(dma_gnt), 32'd0);
    chk_eq("t1_req_bus_wr", 32'(bus_wr), 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      dma_addr = 32'h100 + 32'(4 * k);
      dma_wdata = 32'h11 + 32'(k);
      dma_last = (k == 2);
      #2;
      chk_eq("t1_gnt", 32'(dma_gnt), 32'd1);
      chk_eq("t1_bus_wr", 32'(bus_wr), 32'd1);
      chk_eq("t1_bus_addr", bus_addr, 32'h100 + 32'(4 * k));
      chk_eq("t1_bus_wdata", bus_wdata, 32'h11 + 32'(k));
      chk_eq("t1_sel_mem", 32'(sel_mem), 32'd1);
      chk_eq("t1_stall", 32'(cpu_stall), 32'd0);
      next_cycle();
    end
    dma_req = 0; dma_wr = 0; dma_last = 0;
    #2;
    chk_eq("t1_rel_gnt", 32'(dma_gnt), 32'd0);
    chk_eq("t1_rel_bus_wr", 32'(bus_wr), 32'd0);
    next_cycle();
    next_cycle();

    // CPU monopoly: 8 unstalled CPU cycles, then the DMA is granted
    cpu_rd = 1; cpu_addr = 32'h4000_0020;
    dma_req = 1; dma_rd = 1; dma_addr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk_eq("t2_cpu_gnt", 32'(dma_gnt), 32'd0);
      chk_eq("t2_cpu_stall", 32'(cpu_stall), 32'd0);
      chk_eq("t2_cpu_addr", bus_addr, 32'h4000_0020);
      chk_eq("t2_cpu_rdata", cpu_rdata, 32'd0);
      next_cycle();
    end
    #2;
    chk_eq("t2_dma_gnt", 32'(dma_gnt), 32'd1);
    chk_eq("t2_dma_stall", 32'(cpu_stall), 32'd1);
    chk_eq("t2_dma_addr", bus_addr, 32'h200);
    chk_eq("t2_dma_rdata", dma_rdata, 32'h5A5A_0200);
    chk_eq("t2_dma_cpu_rdata", cpu_rdata, 32'd0);
    next_cycle();
    dma_addr = 32'h204; dma_last = 1;
    #2;
    chk_eq("t2_last_stall", 32'(cpu_stall), 32'd1);
    next_cycle();
    dma_req = 0; dma_rd = 0; dma_last = 0;
    #2;
    chk_eq("t2_rel_gnt", 32'(dma_gnt), 32'd0);
    chk_eq("t2_rel_stall", 32'(cpu_stall), 32'd0);
    chk_eq("t2_rel_addr", bus_addr, 32'h4000_0020);
    next_cycle();
    cpu_rd = 0;
    next_cycle();
    next_cycle();

    // 10-beat DMA read split into 4+4+2 with cool-down gaps
    exp_gnt = 16'b0111_1001_1110_0110;
    beat_no = 0;
    dma_req = 1; dma_rd = 1;
    for (int c = 0; c < 16; c++) begin
      dma_addr = 32'h300 + 32'(4 * beat_no);
      dma_last = (beat_no == 9);
      if (beat_no == 10) begin
        dma_req = 0; dma_rd = 0; dma_last = 0;
      end
      #2;
      chk_eq($sformatf("t3_gnt_c%0d", c), 32'(dma_gnt), 32'(exp_gnt[15-c]));
      chk_eq($sformatf("t3_bus_rd_c%0d", c), 32'(bus_rd), 32'(exp_gnt[15-c]));
      if (dma_gnt) chk_eq($sformatf("t3_rdata_b%0d", beat_no), dma_rdata,
                          (32'h300 + 32'(4 * beat_no)) ^ 32'h5A5A_0000);
      if (dma_gnt && dma_rd) beat_no++;
      next_cycle();
    end
    chk_eq("t3_beats", 32'(beat_no), 32'd10);
    next_cycle();

    // Address decode sweep through CPU reads
    cpu_rd = 1;
    for (int d = 0; d < 6; d++) begin
      cpu_addr = DEC_ADDR[d];
      #2;
      chk_eq($sformatf("t4_sel_%h", DEC_ADDR[d]), 32'({sel_mem, sel_per, sel_uart}), 32'(DEC_SEL[d]));
      chk_eq($sformatf("t4_rdata_%h", DEC_ADDR[d]), cpu_rdata, DEC_DATA[d]);
      next_cycle();
    end
    cpu_rd = 0;
    next_cycle();

    // CPU store held off by a DMA burst, then issued exactly once
    store_seen = 0;
    dma_req = 1; dma_wr = 1; dma_addr = 32'h500; dma_wdata = 32'hD0;
    #2;
    chk_eq("t5_req_gnt", 32'(dma_gnt), 32'd0);
    next_cycle();
    cpu_wr = 1; cpu_addr = 32'h600; cpu_wdata = 32'hCAFE_0001;
    #2;
    chk_eq("t5_b1_stall", 32'(cpu_stall), 32'd1);
    chk_eq("t5_b1_addr", bus_addr, 32'h500);
    chk_eq("t5_b1_wdata", bus_wdata, 32'hD0);
    if (bus_wr && bus_addr == 32'h600) store_seen++;
    next_cycle();
    dma_addr = 32'h504; dma_wdata = 32'hD1; dma_last = 1;
    #2;
    chk_eq("t5_b2_stall", 32'(cpu_stall), 32'd1);
    chk_eq("t5_b2_addr", bus_addr, 32'h504);
    if (bus_wr && bus_addr == 32'h600) store_seen++;
    next_cycle();
    dma_req = 0; dma_wr = 0; dma_last = 0;
    #2;
    chk_eq("t5_rel_stall", 32'(cpu_stall), 32'd0);
    chk_eq("t5_rel_bus_wr", 32'(bus_wr), 32'd1);
    chk_eq("t5_rel_addr", bus_addr, 32'h600);
    chk_eq("t5_rel_wdata", bus_wdata, 32'hCAFE_0001);
    if (bus_wr && bus_addr == 32'h600) store_seen++;
    next_cycle();
    cpu_wr = 0;
    #2;
    if (bus_wr && bus_addr == 32'h600) store_seen++;
    chk_eq("t5_store_count", 32'(store_seen), 32'd1);
    next_cycle();
    next_cycle();

    // Asynchronous reset during beat 2, then a fresh full-length burst
    dma_req = 1; dma_wr = 1; dma_addr = 32'h700; dma_wdata = 32'h70;
    #2;
    chk_eq("t6_req_gnt", 32'(dma_gnt), 32'd0);
    next_cycle();
    #2;
    chk_eq("t6_b1_gnt", 32'(dma_gnt), 32'd1);
    next_cycle();
    dma_addr = 32'h704;
    #2;
    chk_eq("t6_b2_gnt", 32'(dma_gnt), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_eq("t6_rst_gnt", 32'(dma_gnt), 32'd0);
    chk_eq("t6_rst_bus_wr", 32'(bus_wr), 32'd0);
    chk_eq("t6_rst_addr", bus_addr, cpu_addr);
    @(posedge sysclk);
    #3;
    Reset_n = 1'b1;
    #1;
    chk_eq("t6_post_gnt", 32'(dma_gnt), 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      dma_addr = 32'h700 + 32'(4 * k);
      #2;
      chk_eq($sformatf("t6_beat%0d_gnt", k + 1), 32'(dma_gnt), 32'd1);
      next_cycle();
    end
    #2;
    chk_eq("t6_burst_end_gnt", 32'(dma_gnt), 32'd0);
    dma_req = 0; dma_wr = 0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the MEM-stage data bus between the CPU pipeline (EX/MEM register outputs) and a DMA/loader master.
- Decodes the shared address into selects for DataMem, Peripheral and UARTUnit, and returns the ORed slave read data to whichever master owns the bus.
- Stalls the pipeline while the DMA holds the bus.
- Bounds DMA bursts and CPU monopoly so that neither master starves.

Parameters:
- MAX_BURST, 4: maximum DMA beats per grant before forced release.
- STARVE_LIMIT, 8: consecutive cycles a pending dma_req may be refused before the CPU is preempted.

Ports:
- sysclk  in  1  system clock
- Reset_n  in  1  reset, asynchronous, active-low
- cpu_rd  in  1  MEM-stage read strobe
- cpu_wr  in  1  MEM-stage write strobe
- cpu_addr  in  32  MEM-stage address
- cpu_wdata  in  32  MEM-stage write data
- cpu_rdata  out  32  read data to CPU
- cpu_stall  out  1  freezes PC/IFID/IDEX/EXMEM and holds the current MEM access
- dma_req  in  1  DMA requests the bus
- dma_rd  in  1  DMA read strobe (one beat per cycle)
- dma_wr  in  1  DMA write strobe (one beat per cycle)
- dma_last  in  1  current beat is the final beat of the transfer
- dma_addr  in  32  DMA address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA owns the bus (registered)
- dma_rdata  out  32  read data to DMA
- bus_rd  out  1  shared read strobe to slaves
- bus_wr  out  1  shared write strobe to slaves
- bus_addr  out  32  shared address to slaves
- bus_wdata  out  32  shared write data to slaves
- sel_mem  out  1  DataMem select
- sel_per  out  1  Peripheral select
- sel_uart  out  1  UARTUnit select
- bus_rdata  in  32  OR of slave read data

Behaviour:
- Definitions:
  - cpu_active = cpu_rd|cpu_wr
  - beat = dma_gnt & (dma_rd|dma_wr)
- States: OWN_CPU (reset state), OWN_DMA. State, dma_gnt, beat_cnt, starve_cnt and cool are all registered.
- Reset values (asynchronous): state=OWN_CPU, dma_gnt=0, beat_cnt=0, starve_cnt=0, cool=0. Combinational outputs at reset: cpu_stall=0, bus_rd/bus_wr=0 unless cpu_active, dma_rdata=0.
- Bus mux is combinational:
  - OWN_CPU: bus_* = cpu_*; dma_rdata=0; cpu_rdata=bus_rdata.
  - OWN_DMA: bus_* = dma_*; cpu_rdata=0; dma_rdata=bus_rdata.
  - Read data returns in the same cycle as the strobe (zero-latency slaves).
- Address decode on bus_addr, combinational, with at most one select high:
  - sel_mem = bus_addr[31:30]==0.
  - sel_per = bus_addr[31:28]==4 && bus_addr[7:0]<0x18.
  - sel_uart = bus_addr[31:28]==4 && 0x18<=bus_addr[7:0]<0x20.
  - Any other address: no select high, bus_rd/bus_wr still driven. The slaves return 0, so the reader sees 0.
- cpu_stall = cpu_active & (state==OWN_DMA). It is combinational and deasserts in the first OWN_CPU cycle.
- OWN_CPU -> OWN_DMA when dma_req & !cool & (!cpu_active | starve_cnt==STARVE_LIMIT-1). A CPU access in the switching cycle completes normally and is not stalled.
- starve_cnt:
  - Increments each OWN_CPU cycle with dma_req & cpu_active & no transition.
  - Clears when dma_req=0 or on entering OWN_DMA.
  - Saturates at STARVE_LIMIT-1.
- OWN_DMA -> OWN_CPU on the first of:
  - dma_req=0;
  - beat with dma_last=1;
  - beat with beat_cnt==MAX_BURST-1.
- The beat in the exit cycle is performed.
- beat_cnt increments per beat in OWN_DMA and clears on exit.
- cool is set for one cycle after any OWN_DMA -> OWN_CPU exit. This guarantees the CPU at least one bus cycle before regrant.
- DMA strobes while dma_gnt=0 are ignored; the DMA must hold its request and address until it sees dma_gnt. A beat whose strobe is high while dma_gnt=1 is complete in that cycle.
- Simultaneous dma_req rise and cpu_active with starve_cnt=0: the CPU wins.
- Reset mid-burst: the bus returns to the CPU immediately and the burst is abandoned. The DMA must restart the transfer.

Test Plan:
- Idle CPU, dma_req=1, 3 writes to 0x100,0x104,0x108 with dma_last on the third -> dma_gnt rises 1 cycle after req. Three bus_wr pulses with sel_mem=1. dma_gnt falls after the 3rd beat. cpu_stall=0 throughout.
- CPU continuous lw to 0x40000020, DMA requesting -> cpu served 8 cycles (starve_cnt 0..7). The 8th access is unstalled. dma_gnt=1 next. cpu_stall=1 while the DMA owns the bus.
- DMA 10-beat read, CPU idle -> release after beat 4 (MAX_BURST). One cool cycle with dma_gnt=0. Regrant, beats 5-8, cool cycle, regrant, beats 9-10.
- Decode sweep: 0x00000FFC -> sel_mem. 0x40000014 -> sel_per. 0x40000018 and 0x4000001C -> sel_uart. 0x40000020 and 0x80000000 -> no select, rdata 0.
- CPU sw during a DMA burst -> cpu_stall=1 and bus_wr driven by the DMA only. The CPU store appears on the bus exactly once, in the cycle after release.
- Reset_n low mid-burst (beat 2) -> dma_gnt=0 and state OWN_CPU asynchronously. After release, a new req is granted and beat_cnt starts at 0.
